axi_line_bridge: RTL and testbench



---
 rtl/axi_line_bridge_if.sv | 96 +++++++++
 rtl/axi_line_bridge.sv | 182 ++++++++++++++++++
 tb/tb_axi_line_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_bridge_if.sv
// Bundle for axi_line_bridge: i-cache refill port, d-cache port and AXI master channels.
// Latency: none (wires only).
// Backpressure: carries the AXI valid/ready pairs and the cache-side req/ack and wready signals.
// Ports: i_* inst request/response, d_* data request/response/write stream,
//        ar*/r* read channels, aw*/w*/b* write channels.
// Modports: master = the bridge (AXI master, cache-side responder); slave = caches plus AXI slave.
interface axi_line_bridge_if;
  // instruction cache side
  logic        i_req;
  logic        i_burst;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_rvalid;
  logic        i_rlast;
  logic [31:0] i_rdata;
  // data cache side
  logic        d_req;
  logic        d_wr;
  logic        d_burst;
  logic [1:0]  d_size;
  logic [3:0]  d_strb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_wready;
  logic        d_rvalid;
  logic        d_rlast;
  logic [31:0] d_rdata;
  logic        d_bdone;
  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI write address / data / response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  i_req, i_burst, i_addr,
    output i_ack, i_rvalid, i_rlast, i_rdata,
    input  d_req, d_wr, d_burst, d_size, d_strb, d_addr, d_wdata,
    output d_ack, d_wready, d_rvalid, d_rlast, d_rdata, d_bdone,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output i_req, i_burst, i_addr,
    input  i_ack, i_rvalid, i_rlast, i_rdata,
    output d_req, d_wr, d_burst, d_size, d_strb, d_addr, d_wdata,
    input  d_ack, d_wready, d_rvalid, d_rlast, d_rdata, d_bdone,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_line_bridge.sv
// Arbitrates i-cache / d-cache requests onto one AXI master, one transaction at a time (line INCR bursts or single beats).
// Latency: ack in the request cycle, AR/AW valid the next cycle; R beats forwarded combinationally; 1 idle cycle between transactions.
// Backpressure: arready/rready/wready/bvalid stalls are held indefinitely; d_wready mirrors wready so the d-cache steps its write word.
// Ports: clk, rst (synchronous, active-high); io_bus carries the cache-side and AXI signals (see axi_line_bridge_if).
module axi_line_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int I_ID       = 0,
  parameter int D_ID       = 1
) (
  input  logic              clk,
  input  logic              rst,
  axi_line_bridge_if.master io_bus
);

  localparam int          OFF_BITS  = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t      r_state;
  logic        r_prio_d;   // 1: data wins a tie
  logic        r_port_d;   // granted port is the data cache
  logic        r_burst;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [3:0]  r_strb;
  logic [3:0]  r_id;
  logic [7:0]  r_beat;
  logic        r_arvalid;
  logic        r_awvalid;
  logic        r_rready;
  logic        r_wvalid;
  logic        r_bready;

  logic        w_idle;
  logic        w_gnt_d;
  logic        w_gnt_i;
  logic        w_sel_burst;
  logic [31:0] w_sel_addr;
  logic        w_wlast;
  logic        w_unused;

  // Grant decision; only meaningful while idle.
  assign w_idle      = (r_state == S_IDLE);
  assign w_gnt_d     = io_bus.d_req & (~io_bus.i_req | r_prio_d);
  assign w_gnt_i     = io_bus.i_req & ~w_gnt_d;
  assign w_sel_burst = w_gnt_d ? io_bus.d_burst : io_bus.i_burst;
  assign w_sel_addr  = w_gnt_d ? io_bus.d_addr  : io_bus.i_addr;

  // Ack is combinational so the requester sees it in the same cycle the grant is taken.
  assign io_bus.i_ack = w_idle & w_gnt_i;
  assign io_bus.d_ack = w_idle & w_gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_prio_d  <= 1'b1;
      r_port_d  <= 1'b0;
      r_burst   <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_strb    <= '0;
      r_id      <= '0;
      r_beat    <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_d | w_gnt_i) begin
            r_prio_d <= w_gnt_i;  // next tie goes to whoever lost this one
            r_port_d <= w_gnt_d;
            r_burst  <= w_sel_burst;
            r_addr   <= w_sel_burst ? (w_sel_addr & LINE_MASK) : w_sel_addr;
            r_len    <= w_sel_burst ? BURST_LEN : 8'd0;
            // inst accesses are always word sized
            r_size   <= (w_sel_burst | w_gnt_i) ? 3'd2 : {1'b0, io_bus.d_size};
            r_strb   <= io_bus.d_strb;
            r_id     <= w_gnt_d ? 4'(D_ID) : 4'(I_ID);
            if (w_gnt_d & io_bus.d_wr) begin
              r_state   <= S_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (io_bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (io_bus.rvalid & io_bus.rlast) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_AW: begin
          if (io_bus.awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (r_wvalid & io_bus.wready) begin
            if (w_wlast) begin
              r_wvalid <= 1'b0;
              r_beat   <= '0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        S_B: begin
          if (io_bus.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read address channel
  assign io_bus.arid    = r_id;
  assign io_bus.araddr  = r_addr;
  assign io_bus.arlen   = r_len;
  assign io_bus.arsize  = r_size;
  assign io_bus.arburst = 2'b01;
  assign io_bus.arvalid = r_arvalid;
  assign io_bus.rready  = r_rready;

  // Read beats steered to the granted port only; r_rready doubles as "in R".
  assign io_bus.i_rvalid = r_rready & ~r_port_d & io_bus.rvalid;
  assign io_bus.i_rlast  = r_rready & ~r_port_d & io_bus.rlast;
  assign io_bus.i_rdata  = io_bus.rdata;
  assign io_bus.d_rvalid = r_rready & r_port_d & io_bus.rvalid;
  assign io_bus.d_rlast  = r_rready & r_port_d & io_bus.rlast;
  assign io_bus.d_rdata  = io_bus.rdata;

  // Write address / data / response channels
  assign w_wlast         = (r_beat == r_len);
  assign io_bus.awid     = r_id;
  assign io_bus.awaddr   = r_addr;
  assign io_bus.awlen    = r_len;
  assign io_bus.awsize   = r_size;
  assign io_bus.awburst  = 2'b01;
  assign io_bus.awvalid  = r_awvalid;
  assign io_bus.wid      = r_id;
  assign io_bus.wdata    = io_bus.d_wdata;
  assign io_bus.wstrb    = r_burst ? 4'hF : r_strb;
  assign io_bus.wlast    = w_wlast;
  assign io_bus.wvalid   = r_wvalid;
  assign io_bus.d_wready = r_wvalid & io_bus.wready;
  assign io_bus.bready   = r_bready;
  assign io_bus.d_bdone  = r_bready & io_bus.bvalid;

  // Response IDs and status codes carry no information for this bridge.
  assign w_unused = ^{io_bus.rid, io_bus.rresp, io_bus.bid, io_bus.bresp};

endmodule

// File: tb/tb_axi_line_bridge.sv
// Scoreboard bench for axi_line_bridge: directed requests push expected grants/AXI fields/beats; a negedge monitor pops and compares.
// Latency: driven by the simple AXI slave model below (optional AR stall, R gaps, W ready toggling).
// Backpressure: slave model stalls arready, gaps rvalid and toggles wready on demand.
module tb_axi_line_bridge;

  localparam logic [31:0] RK = 32'h5A5A_0000;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_t;

  logic clk;
  logic rst;
  axi_line_bridge_if bus ();

  axi_line_bridge #(.LINE_WORDS(8), .I_ID(0), .D_ID(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  ax_t         ar_q[$];
  ax_t         aw_q[$];
  logic [40:0] w_q[$];
  logic [32:0] ir_q[$];
  logic [32:0] dr_q[$];
  logic [1:0]  g_q[$];
  int          b_q[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          bdone_seen = 0;
  int          ar_stall = 0;
  bit          r_gap = 0;
  bit          w_toggle = 0;
  logic [31:0] wd_base = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output seen with no expected entry", name);
  endtask

  task automatic push_r(input bit port_d, input logic [31:0] base, input int len);
    for (int k = 0; k <= len; k++) begin
      if (port_d) dr_q.push_back({(base + 32'(4 * k)) ^ RK, k == len});
      else        ir_q.push_back({(base + 32'(4 * k)) ^ RK, k == len});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        if (g_q.size() == 0) miss("grant");
        else chk("grant", 64'({bus.i_ack, bus.d_ack}), 64'(g_q.pop_front()));
      end
      if (bus.arvalid && bus.arready) begin
        if (ar_q.size() == 0) miss("ar");
        else chk("ar_fields", 64'({bus.arid, bus.araddr, bus.arlen, bus.arsize}), 64'(ar_q.pop_front()));
        chk("arburst", 64'(bus.arburst), 64'(2'b01));
      end
      if (prev_wait) begin
        chk("ar_hold_vld", 64'(bus.arvalid), 64'(1));
        chk("ar_hold_addr", 64'(bus.araddr), 64'(prev_addr));
      end
      prev_wait = bus.arvalid && !bus.arready;
      prev_addr = bus.araddr;
      if (bus.awvalid && bus.awready) begin
        if (aw_q.size() == 0) miss("aw");
        else chk("aw_fields", 64'({bus.awid, bus.awaddr, bus.awlen, bus.awsize}), 64'(aw_q.pop_front()));
        chk("awburst", 64'(bus.awburst), 64'(2'b01));
      end
      if (bus.wvalid && bus.wready) begin
        if (w_q.size() == 0) miss("w_beat");
        else chk("w_beat", 64'({bus.wid, bus.wdata, bus.wstrb, bus.wlast}), 64'(w_q.pop_front()));
      end
      if (bus.i_rvalid) begin
        if (ir_q.size() == 0) miss("i_rbeat");
        else chk("i_rbeat", 64'({bus.i_rdata, bus.i_rlast}), 64'(ir_q.pop_front()));
      end
      if (bus.d_rvalid) begin
        if (dr_q.size() == 0) miss("d_rbeat");
        else chk("d_rbeat", 64'({bus.d_rdata, bus.d_rlast}), 64'(dr_q.pop_front()));
      end
      if (bus.d_bdone) begin
        bdone_seen++;
        if (b_q.size() == 0) miss("d_bdone");
        else chk("d_bdone_seq", 64'(bdone_seen), 64'(b_q.pop_front()));
      end
    end
  end

  // ---------------- AXI read slave ----------------
  initial begin : slave_r
    logic [31:0] a;
    logic [7:0]  l;
    logic [3:0]  id;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rlast = 0; bus.rid = '0; bus.rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.arvalid && !rst) begin
        for (int s = 0; s < ar_stall; s++) begin
          @(posedge clk); #1;
        end
        bus.arready = 1; a = bus.araddr; l = bus.arlen; id = bus.arid;
        @(posedge clk); #1;
        bus.arready = 0;
        for (int k = 0; k <= int'(l); k++) begin
          if (r_gap && k[0]) begin
            @(posedge clk); #1;
          end
          bus.rvalid = 1; bus.rid = id;
          bus.rdata  = (a + 32'(4 * k)) ^ RK;
          bus.rlast  = (k == int'(l));
          @(posedge clk); #1;
          bus.rvalid = 0; bus.rlast = 0;
          if (rst) break;
        end
      end
    end
  end

  // ---------------- AXI write slave ----------------
  initial begin : slave_w
    logic done;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.awvalid) begin
        bus.awready = 1;
        @(posedge clk); #1;
        bus.awready = 0;
        bus.wready = 1;
        done = 0;
        for (int g = 0; g < 64 && !done; g++) begin
          @(negedge clk);
          done = bus.wvalid && bus.wready && bus.wlast;
          @(posedge clk); #1;
          if (!done && w_toggle) bus.wready = !bus.wready;
        end
        bus.wready = 0;
        @(posedge clk); #1;
        bus.bvalid = 1; bus.bid = 4'd1;
        @(posedge clk); #1;
        bus.bvalid = 0;
      end
    end
  end

  // ---------------- d-cache write word feeder ----------------
  initial begin : wfeed
    logic ack_s;
    logic step_s;
    int   idx;
    idx = 0;
    bus.d_wdata = '0;
    forever begin
      @(negedge clk);
      ack_s  = bus.d_ack;
      step_s = bus.d_wready;
      @(posedge clk); #1;
      if (ack_s) idx = 0;
      else if (step_s) idx++;
      bus.d_wdata = wd_base + 32'(idx);
    end
  end

  // ---------------- requesters ----------------
  task automatic i_request(input logic burst, input logic [31:0] addr);
    bit got = 0;
    bus.i_burst = burst; bus.i_addr = addr; bus.i_req = 1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.i_ack) got = 1;
    end
    @(posedge clk); #1;
    bus.i_req = 0;
    if (!got) miss("i_ack_timeout");
  endtask

  task automatic d_request(input logic wr, input logic burst, input logic [1:0] size,
                           input logic [3:0] strb, input logic [31:0] addr);
    bit got = 0;
    bus.d_wr = wr; bus.d_burst = burst; bus.d_size = size; bus.d_strb = strb;
    bus.d_addr = addr; bus.d_req = 1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.d_ack) got = 1;
    end
    @(posedge clk); #1;
    bus.d_req = 0;
    if (!got) miss("d_ack_timeout");
  endtask

  function automatic int pending();
    return ar_q.size() + aw_q.size() + w_q.size() + ir_q.size() + dr_q.size() + g_q.size() + b_q.size();
  endfunction

  task automatic drain(input string tag);
    bit empty = 0;
    for (int c = 0; c < 600 && !empty; c++) begin
      @(negedge clk);
      if (pending() == 0) empty = 1;
    end
    if (!empty) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_%s: pending=%0d required=0", tag, pending());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    bit hit;
    int n;
    rst = 1;
    bus.i_req = 0; bus.i_burst = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_burst = 0; bus.d_size = '0; bus.d_strb = '0; bus.d_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({bus.arvalid, bus.awvalid, bus.rready, bus.wvalid, bus.bready, bus.i_ack,
                              bus.d_ack, bus.d_bdone, bus.i_rvalid, bus.d_rvalid, bus.d_wready}), 64'(0));
    rst = 0;
    @(posedge clk); #1;

    // Tie after reset: data single read first, then the inst line read.
    g_q.push_back(2'b01); g_q.push_back(2'b10);
    ar_q.push_back('{4'd1, 32'h0000_1008, 8'd0, 3'd2});
    ar_q.push_back('{4'd0, 32'h1FC0_0000, 8'd7, 3'd2});
    push_r(1, 32'h0000_1008, 0);
    push_r(0, 32'h1FC0_0000, 7);
    fork
      i_request(1'b1, 32'h1FC0_0014);
      d_request(1'b0, 1'b0, 2'd2, 4'hF, 32'h0000_1008);
    join
    drain("arb1");

    // Tie again: inst was granted last, so data wins again (alternation).
    g_q.push_back(2'b01); g_q.push_back(2'b10);
    ar_q.push_back('{4'd1, 32'h8000_0040, 8'd7, 3'd2});
    ar_q.push_back('{4'd0, 32'h0000_0104, 8'd0, 3'd2});
    push_r(1, 32'h8000_0040, 7);
    push_r(0, 32'h0000_0104, 0);
    fork
      i_request(1'b0, 32'h0000_0104);
      d_request(1'b0, 1'b1, 2'd2, 4'hF, 32'h8000_0047);
    join
    drain("arb2");

    // Inst line read with arready stalled 5 cycles and gaps between R beats.
    ar_stall = 5; r_gap = 1;
    g_q.push_back(2'b10);
    ar_q.push_back('{4'd0, 32'h1FC0_0000, 8'd7, 3'd2});
    push_r(0, 32'h1FC0_0000, 7);
    i_request(1'b1, 32'h1FC0_0014);
    drain("stall");
    ar_stall = 0; r_gap = 0;

    // Uncached byte store.
    wd_base = 32'h0000_AB00;
    g_q.push_back(2'b01);
    aw_q.push_back('{4'd1, 32'h1FAF_F002, 8'd0, 3'd0});
    w_q.push_back({4'd1, 32'h0000_AB00, 4'b0100, 1'b1});
    b_q.push_back(1);
    d_request(1'b1, 1'b0, 2'd0, 4'b0100, 32'h1FAF_F002);
    drain("store");

    // Line write-back, wready toggling; strobes forced to all-ones.
    wd_base = 32'h0;
    w_toggle = 1;
    g_q.push_back(2'b01);
    aw_q.push_back('{4'd1, 32'h0000_2060, 8'd7, 3'd2});
    for (int k = 0; k < 8; k++) w_q.push_back({4'd1, 32'(k), 4'hF, k == 7});
    b_q.push_back(2);
    d_request(1'b1, 1'b1, 2'd2, 4'h0, 32'h0000_2064);
    drain("wb");
    w_toggle = 0;

    // Reset on the third R beat of an inst line read.
    g_q.push_back(2'b10);
    ar_q.push_back('{4'd0, 32'h0000_3000, 8'd7, 3'd2});
    push_r(0, 32'h0000_3000, 7);
    i_request(1'b1, 32'h0000_301C);
    hit = 0; n = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (bus.i_rvalid) n++;
      if (n == 3) begin
        rst = 1;
        hit = 1;
      end
    end
    if (!hit) miss("rst_beat3_timeout");
    @(negedge clk);
    chk("rst_rready", 64'(bus.rready), 64'(0));
    chk("rst_arvalid", 64'(bus.arvalid), 64'(0));
    chk("rst_i_rvalid", 64'(bus.i_rvalid), 64'(0));
    chk("rst_beats_seen", 64'(ir_q.size()), 64'(5));
    rst = 0;
    ir_q.delete();
    @(posedge clk); #1;

    // Fresh request after reset is accepted normally.
    g_q.push_back(2'b10);
    ar_q.push_back('{4'd0, 32'h0000_3010, 8'd0, 3'd2});
    push_r(0, 32'h0000_3010, 0);
    i_request(1'b0, 32'h0000_3010);
    drain("post_rst");

    chk("queues_empty", 64'(pending()), 64'(0));
    chk("bdone_total", 64'(bdone_seen), 64'(2));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
